// File: rtl/stage6_operand_feeder_pkg.sv
// Shared types for the stage-6 operand feeder: beat layout, boundary table and
// feeder state encoding.
package stage6_pkg;

    localparam int WIDTH         = 16;
    localparam int PARALLEL_SIZE = 3;
    localparam int TILE_SIZE     = 128;
    localparam int PARA          = 16;
    localparam int BND_N         = 8;

    localparam int VEC_W = PARALLEL_SIZE * TILE_SIZE * WIDTH;
    localparam int SCA_W = PARALLEL_SIZE * WIDTH;

    typedef logic [VEC_W-1:0]            vec_t;
    typedef logic [SCA_W-1:0]            sca_t;
    typedef logic [PARA-1:0]             cnt_t;
    typedef logic [BND_N-1:0][PARA-1:0]  bnd_t;

    typedef struct packed {
        vec_t v;
        sca_t op1;
        sca_t op2;
        sca_t op3;
        sca_t op4;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_RUN,
        ST_DONE
    } feeder_state_e;

    function automatic cnt_t min_cnt(input cnt_t a, input cnt_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/stage6_operand_feeder_if.sv
// Upstream operand-beat stream (valid/ready) feeding the stage-6 operand feeder.
interface stage6_operand_feeder_if;
    import stage6_pkg::*;

    logic  valid;
    logic  ready;
    beat_t beat;

    modport master (output valid, output beat, input ready);
    modport slave  (input valid, input beat, output ready);

endinterface

// File: rtl/stage6_operand_feeder_beat_fifo.sv
// Small beat FIFO; the head reads back as zero whenever the FIFO is empty so
// the consumer never sees stale data.
module stage6_beat_fifo
    import stage6_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  beat_t                    din_i,
    output beat_t                    head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);

    beat_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push;
    logic           do_pop;

    assign do_push = push_i && (count_q != FULL_C);
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (!do_push && do_pop) count_q <= count_q - CNT_ONE;
        end
    end

    // Storage carries no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/stage6_operand_feeder.sv
// Prefetches operand beats, holds the stage-6 core in reset until PREFILL beats
// are buffered, then presents one beat per clock in lock-step with the core.
module stage6_operand_feeder
    import stage6_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PREFILL = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  cnt_t                          total_steps_i,
    input  bnd_t                          cfg_boundary_i,
    stage6_operand_feeder_if.slave        in_if,
    output logic                          core_rst_o,
    output vec_t                          operandv_o,
    output sca_t                          operand1_o,
    output sca_t                          operand2_o,
    output sca_t                          operand3_o,
    output sca_t                          operand4_o,
    output bnd_t                          stage_boundary_o,
    input  logic                          finished_i,
    output logic                          done_o,
    output logic                          underrun_o,
    output logic                          busy_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam cnt_t        PREFILL_C = cnt_t'(PREFILL);
    localparam cnt_t        ONE_C     = cnt_t'(1);

    feeder_state_e state_q;
    cnt_t          total_q;
    cnt_t          rcv_q;
    cnt_t          rcv_d;
    cnt_t          sent_q;
    bnd_t          bnd_q;
    logic          core_rst_q;
    logic          ready_q;
    logic          underrun_q;
    logic          done_q;

    logic [AW:0]   count;
    logic [AW:0]   count_d;
    logic          start_ok;
    logic          push;
    logic          due;
    logic          pop;
    beat_t         head;
    beat_t         out_beat;

    function automatic logic ready_next(input logic [AW:0] cnt, input cnt_t rcv, input cnt_t total);
        return (cnt < DEPTH_C) && (rcv < total);
    endfunction

    assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign push     = in_if.valid && ready_q;
    assign due      = (state_q == ST_RUN) && (sent_q < total_q);
    assign pop      = due && (count != '0);
    assign rcv_d    = push ? (rcv_q + ONE_C) : rcv_q;

    // Next occupancy lets in_ready be registered yet exact for the coming cycle.
    always_comb begin
        count_d = count;
        if (push && !pop)      count_d = count + CNT_ONE;
        else if (!push && pop) count_d = count - CNT_ONE;
    end

    stage6_beat_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (start_ok),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (in_if.beat),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            total_q    <= '0;
            bnd_q      <= '0;
            rcv_q      <= '0;
            sent_q     <= '0;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    ready_q <= 1'b0;
                    if (start_i) begin
                        state_q    <= ST_PREFILL;
                        total_q    <= total_steps_i;
                        bnd_q      <= cfg_boundary_i;
                        rcv_q      <= '0;
                        sent_q     <= '0;
                        underrun_q <= 1'b0;
                        done_q     <= 1'b0;
                        core_rst_q <= 1'b1;
                        ready_q    <= (total_steps_i != '0);
                    end
                end
                ST_PREFILL: begin
                    rcv_q   <= rcv_d;
                    ready_q <= ready_next(count_d, rcv_d, total_q);
                    if (cnt_t'(count) >= min_cnt(PREFILL_C, total_q)) begin
                        state_q    <= ST_RUN;
                        core_rst_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    rcv_q   <= rcv_d;
                    ready_q <= ready_next(count_d, rcv_d, total_q);
                    // The core cannot stall: a due beat is spent even when none is buffered.
                    if (due) begin
                        sent_q <= sent_q + ONE_C;
                        if (count == '0) underrun_q <= 1'b1;
                    end else if (finished_i) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_beat = due ? head : '0;

    assign in_if.ready      = ready_q;
    assign core_rst_o       = core_rst_q;
    assign operandv_o       = out_beat.v;
    assign operand1_o       = out_beat.op1;
    assign operand2_o       = out_beat.op2;
    assign operand3_o       = out_beat.op3;
    assign operand4_o       = out_beat.op4;
    assign stage_boundary_o = bnd_q;
    assign done_o           = done_q;
    assign underrun_o       = underrun_q || (due && (count == '0));
    assign busy_o           = (state_q == ST_PREFILL) || (state_q == ST_RUN);

endmodule

// File: tb/tb_stage6_operand_feeder.sv
// Bench for stage6_operand_feeder: random beats against a queue-based model of
// the feeder, plus literal expectations for the scenarios of interest.
module tb_stage6_operand_feeder;
    import stage6_pkg::*;

    localparam int DEPTH   = 4;
    localparam int PREFILL = 4;
    localparam int P_IDLE = 0, P_PRE = 1, P_RUN = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic finished_i = 1'b0;
    cnt_t total_steps_i = '0;
    bnd_t cfg_boundary_i = '0;
    logic core_rst_o, done_o, underrun_o, busy_o;
    vec_t operandv_o;
    sca_t operand1_o, operand2_o, operand3_o, operand4_o;
    bnd_t stage_boundary_o;

    stage6_operand_feeder_if u_if ();

    stage6_operand_feeder #(.DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .total_steps_i    (total_steps_i),
        .cfg_boundary_i   (cfg_boundary_i),
        .in_if            (u_if),
        .core_rst_o       (core_rst_o),
        .operandv_o       (operandv_o),
        .operand1_o       (operand1_o),
        .operand2_o       (operand2_o),
        .operand3_o       (operand3_o),
        .operand4_o       (operand4_o),
        .stage_boundary_o (stage_boundary_o),
        .finished_i       (finished_i),
        .done_o           (done_o),
        .underrun_o       (underrun_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    task automatic chk_w(input string nm, input bit eq, input logic [63:0] got_lo, input logic [63:0] exp_lo);
        nchk++;
        if (eq) npass++;
        else $display("FAIL %s: got low word 0x%0h, expected low word 0x%0h", nm, got_lo, exp_lo);
    endtask

    // Reference model: accepted beats queue up and leave one per due cycle.
    int     m_phase = P_IDLE;
    int     m_total = 0;
    int     m_rcv = 0;
    int     m_sent = 0;
    bit     m_und = 0;
    bit     m_done = 0;
    bnd_t   m_bnd = '0;
    beat_t  m_q[$];

    function automatic bit m_ready();
        return (m_phase == P_PRE || m_phase == P_RUN) && (m_q.size() < DEPTH) && (m_rcv < m_total);
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        if (rst_i) begin
            m_phase = P_IDLE; m_total = 0; m_rcv = 0; m_sent = 0;
            m_und = 0; m_done = 0; m_bnd = '0; m_q.delete();
        end else begin
            acc = u_if.valid && m_ready();
            case (m_phase)
                P_IDLE, P_DONE: if (start_i) begin
                    m_phase = P_PRE; m_total = int'(total_steps_i); m_bnd = cfg_boundary_i;
                    m_rcv = 0; m_sent = 0; m_und = 0; m_done = 0; m_q.delete();
                end
                P_PRE: if (m_q.size() >= ((PREFILL < m_total) ? PREFILL : m_total)) m_phase = P_RUN;
                P_RUN: begin
                    if (m_sent < m_total) begin
                        if (m_q.size() == 0) m_und = 1;
                        else void'(m_q.pop_front());
                        m_sent++;
                    end else if (finished_i) begin
                        m_phase = P_DONE; m_done = 1;
                    end
                end
                default: ;
            endcase
            if (acc) begin
                m_q.push_back(u_if.beat);
                m_rcv++;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit due;
        beat_t eb;
        due = (m_phase == P_RUN) && (m_sent < m_total);
        eb = '0;
        if (due && m_q.size() > 0) eb = m_q[0];
        chk("in_ready", u_if.ready, m_ready());
        chk("core_rst", core_rst_o, (m_phase == P_IDLE || m_phase == P_PRE));
        chk("busy", busy_o, (m_phase == P_PRE || m_phase == P_RUN));
        chk("done", done_o, m_done);
        chk("underrun", underrun_o, m_und || (due && m_q.size() == 0));
        chk_w("boundary", stage_boundary_o === m_bnd, 64'(stage_boundary_o), 64'(m_bnd));
        chk("op1", operand1_o, eb.op1);
        chk("op2", operand2_o, eb.op2);
        chk("op3", operand3_o, eb.op3);
        chk("op4", operand4_o, eb.op4);
        chk_w("opv", operandv_o === eb.v, operandv_o[63:0], eb.v[63:0]);
    end

    // Upstream source: beat k carries op1 = k, everything else random.
    int src_total = 0, src_k = 0, stall_at = -1, stall_len = 0, stall_cnt = 0;
    bit fire = 0, have_beat = 0;

    function automatic beat_t make_beat(input int k);
        beat_t b;
        for (int i = 0; i < VEC_W / 32; i++) b.v[i*32 +: 32] = $urandom();
        b.op1 = sca_t'(k);
        b.op2 = sca_t'({$urandom(), $urandom()});
        b.op3 = sca_t'({$urandom(), $urandom()});
        b.op4 = sca_t'({$urandom(), $urandom()});
        return b;
    endfunction

    task automatic step();
        @(negedge clk);
        if (fire) begin
            src_k++;
            have_beat = 0;
        end
        if (src_k >= src_total) begin
            u_if.valid = 1'b0;
        end else if (src_k == stall_at && stall_cnt < stall_len) begin
            u_if.valid = 1'b0;
            stall_cnt++;
        end else begin
            if (!have_beat) begin
                u_if.beat = make_beat(src_k);
                have_beat = 1;
            end
            u_if.valid = 1'b1;
        end
        fire = u_if.valid && u_if.ready;
    endtask

    task automatic begin_run(input int total, input int sat, input int slen, input cnt_t b0);
        src_total = total; src_k = 0; fire = 0; have_beat = 0;
        stall_at = sat; stall_len = slen; stall_cnt = 0;
        for (int i = 0; i < BND_N; i++) cfg_boundary_i[i] = cnt_t'($urandom());
        cfg_boundary_i[0] = b0;
        total_steps_i = cnt_t'(total);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_release();
        int n = 0;
        while (core_rst_o && n < 40) begin
            step();
            n++;
        end
        chk("release_timeout", core_rst_o, 1'b0);
    endtask

    task automatic finish_run(input string nm);
        finished_i = 1'b1;
        chk({nm, "_done_before"}, done_o, 1'b0);
        step();
        finished_i = 1'b0;
        chk({nm, "_done_after"}, done_o, 1'b1);
        chk({nm, "_core_held"}, core_rst_o, 1'b0);
    endtask

    initial begin
        u_if.valid = 1'b0;
        u_if.beat  = '0;
        step();
        step();
        chk("rst_core_rst", core_rst_o, 1'b1);
        chk("rst_in_ready", u_if.ready, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_underrun", underrun_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_op1", operand1_o, '0);
        chk_w("rst_boundary", stage_boundary_o === '0, 64'(stage_boundary_o), 64'd0);
        rst_i = 1'b0;
        step();

        // Basic run
        begin_run(6, -1, 0, 16'd11);
        wait_release();
        chk("basic_accepts_at_release", 64'(src_k), 64'd4);
        for (int i = 0; i < 7; i++) begin
            chk("basic_op1", operand1_o, (i < 6) ? 64'(i) : 64'd0);
            step();
        end
        finish_run("basic");

        // Underrun: beat 4 held back long enough to miss its slot
        begin_run(8, 4, 6, 16'd3);
        wait_release();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) chk("und_before", underrun_o, 1'b0);
            if (i == 4) begin
                chk("und_set", underrun_o, 1'b1);
                chk("und_zero_op1", operand1_o, '0);
            end
            if (i == 6) chk("und_late_beat", operand1_o, 64'd4);
            if (i == 8) chk("und_after_total", operand1_o, '0);
            step();
        end
        chk("und_sticky", underrun_o, 1'b1);
        finish_run("und");

        // Backpressure: FIFO full at release, then in-order delivery
        begin_run(10, -1, 0, 16'd1);
        wait_release();
        chk("bp_ready_full", u_if.ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_op1", operand1_o, 64'(i));
            step();
        end
        chk("bp_no_underrun", underrun_o, 1'b0);
        finish_run("bp");

        // Config latch
        begin_run(4, -1, 0, 16'd5);
        for (int i = 0; i < BND_N; i++) cfg_boundary_i[i] = cnt_t'($urandom());
        cfg_boundary_i[0] = 16'd9;
        wait_release();
        chk("cfg_bnd_run", 64'(stage_boundary_o[0]), 64'd5);
        repeat (4) step();
        chk("cfg_bnd_late", 64'(stage_boundary_o[0]), 64'd5);
        finish_run("cfg");
        chk("cfg_bnd_done", 64'(stage_boundary_o[0]), 64'd5);

        // Zero length
        begin_run(0, -1, 0, 16'd7);
        chk("zero_busy", busy_o, 1'b1);
        chk("zero_core_rst", core_rst_o, 1'b1);
        chk("zero_bnd_new", 64'(stage_boundary_o[0]), 64'd7);
        step();
        chk("zero_released", core_rst_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("zero_ready", u_if.ready, 1'b0);
            chk("zero_op1", operand1_o, '0);
            step();
        end
        finish_run("zero");

        // Reset in the middle of a run
        begin_run(10, -1, 0, 16'd2);
        wait_release();
        repeat (3) step();
        chk("mid_op1_before", operand1_o, 64'd3);
        #2;
        rst_i = 1'b1;
        src_total = 0; fire = 0; u_if.valid = 1'b0;
        #1;
        chk("mid_core_rst", core_rst_o, 1'b1);
        chk("mid_busy", busy_o, 1'b0);
        chk("mid_ready", u_if.ready, 1'b0);
        chk("mid_op1_zero", operand1_o, '0);
        step();
        rst_i = 1'b0;
        step();
        chk("mid_idle", busy_o, 1'b0);
        begin_run(4, -1, 0, 16'd4);
        wait_release();
        for (int i = 0; i < 4; i++) begin
            chk("rerun_op1", operand1_o, 64'(i));
            step();
        end
        finish_run("rerun");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
